// File: rtl/adr_pkg.sv
// Shared types and defaults for the address request path.
package adr_pkg;

    localparam int ADR_WIDTH = 64;
    localparam int ADR_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } adr_state_e;

endpackage

// File: rtl/adr_req_issuer_if.sv
// FIFO read port plus request channel towards the PHY TX.
interface adr_req_issuer_if #(
    parameter int WIDTH = adr_pkg::ADR_WIDTH,
    parameter int TAG_W = adr_pkg::ADR_TAG_W
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;
    logic             fifo_rd;
    logic             req_valid;
    logic [WIDTH-1:0] req_data;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;

    modport master (
        input  fifo_empty, fifo_rdata, req_ready,
        output fifo_rd, req_valid, req_data, req_tag
    );

    modport slave (
        output fifo_empty, fifo_rdata, req_ready,
        input  fifo_rd, req_valid, req_data, req_tag
    );
endinterface

// File: rtl/adr_credit_ctr.sv
// Remote-slot credit counter: take on dec, return on inc, saturating with a sticky error.
// Latency: count updates on the edge after inc/dec.
// Backpressure: none; the caller must only dec while avail is high.
module adr_credit_ctr #(
    parameter int MAX    = 8,
    parameter int CRED_W = $clog2(MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [CRED_W-1:0] count,
    output logic              avail,
    output logic              err
);
    localparam logic [CRED_W-1:0] FULL = CRED_W'(MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= FULL;
            err   <= 1'b0;
        end else if (dec && !inc) begin
            count <= count - CRED_W'(1);
        end else if (inc && !dec) begin
            // A return with every slot already free means the far end miscounted.
            if (count == FULL) err <= 1'b1;
            else               count <= count + CRED_W'(1);
        end
    end

    assign avail = (count != '0);

endmodule

// File: rtl/adr_req_issuer.sv
// Pops address words from a FWFT FIFO and issues them as tagged requests, credit and gap limited.
// Latency: request valid one cycle after the pop; back-to-back when GAP_CYC is 0.
// Backpressure: a request holds data/tag until req_ready; no pops while held or out of credits.
module adr_req_issuer
    import adr_pkg::*;
#(
    parameter int WIDTH       = ADR_WIDTH,
    parameter int TAG_W       = ADR_TAG_W,
    parameter int MAX_CREDITS = 8,
    parameter int GAP_CYC     = 0,
    parameter int CRED_W      = $clog2(MAX_CREDITS + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    adr_req_issuer_if.master  bus,
    input  logic              cred_ret,
    output logic [CRED_W-1:0] credits,
    output logic              cred_err,
    output logic [31:0]       issued_cnt
);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    adr_state_e       state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic [TAG_W-1:0] tag_q;
    logic [TAG_W-1:0] tag_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             can_pop, accept, pop, valid, cred_avail, gap_done;

    assign accept   = (state_q == HOLD) & bus.req_ready;
    assign can_pop  = enable & ~bus.fifo_empty & cred_avail & ~reset;
    assign gap_done = (gap_cnt == '0);

    adr_credit_ctr #(
        .MAX    (MAX_CREDITS),
        .CRED_W (CRED_W)
    ) u_cred (
        .clk   (clk),
        .reset (reset),
        .inc   (cred_ret),
        .dec   (pop),
        .count (credits),
        .avail (cred_avail),
        .err   (cred_err)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (can_pop) state_d = HOLD;
            HOLD: begin
                if (accept) begin
                    if (GAP_CYC > 0)   state_d = GAP;
                    else if (!can_pop) state_d = IDLE;
                end
            end
            // The final gap cycle doubles as the pop cycle, so the bus sees exactly GAP_CYC idle cycles.
            GAP:  if (gap_done) state_d = can_pop ? HOLD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop   = 1'b0;
        valid = 1'b0;
        case (state_q)
            IDLE: pop = can_pop;
            HOLD: begin
                valid = 1'b1;
                pop   = accept & (GAP_CYC == 0) & can_pop;
            end
            GAP:  pop = gap_done & can_pop;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= '0;
            tag_q      <= '0;
            tag_cnt    <= '0;
            gap_cnt    <= '0;
            issued_cnt <= '0;
        end else begin
            if (pop) begin
                data_q  <= bus.fifo_rdata;
                tag_q   <= tag_cnt;
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
            if (accept) issued_cnt <= issued_cnt + 32'd1;
            if (accept && GAP_CYC > 0)
                gap_cnt <= GAP_W'(GAP_CYC - 1);
            else if (state_q == GAP && !gap_done)
                gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign bus.fifo_rd   = pop;
    assign bus.req_valid = valid;
    assign bus.req_data  = data_q;
    assign bus.req_tag   = tag_q;

endmodule
